// File: rtl/scanner_link_pkg.sv
// Constants shared by both ends of the scanner serial link: link FSM state
// encoding, default word/frame sizes and the serial bit order.
package scanner_link_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int FRAME_BYTES_DEF = 8;
   // 1: the first serial bit of a word is its MSB
   localparam bit MSB_FIRST       = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_RECV  = 2'd2,
      ST_ERR   = 2'd3
   } link_state_t;

endpackage

// File: rtl/scanner_receiver_if.sv
// Pin bundle of the scanner receiver: the serial side from the scanner and the
// FIFO/status side towards the consumer.
interface scanner_receiver_if
   import scanner_link_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 16
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              serialClk;
   logic              serialData;
   logic              readyForTransfer;
   logic              transferActive;
   logic              frameDone;
   logic              frameError;
   logic              clrError;
   logic              rdEn;
   logic [DATA_W-1:0] rdData;
   logic              empty;
   logic              full;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  serialClk, serialData, clrError, rdEn,
      output readyForTransfer, transferActive, frameDone, frameError,
             rdData, empty, full, count
   );

   modport master (
      output serialClk, serialData, clrError, rdEn,
      input  readyForTransfer, transferActive, frameDone, frameError,
             rdData, empty, full, count
   );
endinterface

// File: rtl/scanner_rx_fifo.sv
// Receive buffer: block-RAM style array with a registered read port, natural
// pointer wrap and an occupancy counter.
module scanner_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int AW        = $clog2(FIFO_DEPTH),
   localparam int CW        = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic [CW-1:0]     count,
   output logic              overflow
);
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic              push;
   logic              pop;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CW'(FIFO_DEPTH));
   assign push     = wr_en && !full;
   assign pop      = rd_en && !empty;
   // a write into a full buffer is dropped and reported upstream
   assign overflow = wr_en && full;
   assign count    = count_reg;
   assign rd_data  = rd_data_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         rd_data_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + AW'(1);
            rd_data_reg <= mem[rd_ptr_reg];
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/scanner_receiver.sv
// Receiving end of the scanner serial link: grants a frame, deserialises the
// clkOut/dataOut stream into words and buffers them for the consumer.
module scanner_receiver
   import scanner_link_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int FRAME_BYTES = FRAME_BYTES_DEF,
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT     = 64
) (
   input  logic             clk,
   input  logic             rst,
   scanner_receiver_if.slave bus
);
   localparam int CW     = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int WORD_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

   logic [2:0]        sclk_sync_reg;
   logic [1:0]        sdat_sync_reg;
   link_state_t       state_reg, state_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [WORD_W-1:0] word_cnt_reg, word_cnt_next;
   logic [TMO_W-1:0]  idle_cnt_reg, idle_cnt_next;
   logic              frame_done_reg, frame_done_next;
   logic              frame_error_reg, frame_error_next;

   logic              serial_edge;
   logic              serial_bit;
   logic [DATA_W-1:0] shift_in;
   logic              push;
   logic              space_ok;
   logic              overflow;
   logic [CW-1:0]     fifo_count;

   // third stage exists only to detect the rising edge of the synced clock
   assign serial_edge = sclk_sync_reg[1] & ~sclk_sync_reg[2];
   assign serial_bit  = sdat_sync_reg[1];
   assign shift_in    = MSB_FIRST ? {shift_reg[DATA_W-2:0], serial_bit}
                                  : {serial_bit, shift_reg[DATA_W-1:1]};
   assign space_ok    = (CW'(FIFO_DEPTH) - fifo_count) >= CW'(FRAME_BYTES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_reg   <= '0;
         sdat_sync_reg   <= '0;
         state_reg       <= ST_IDLE;
         shift_reg       <= '0;
         bit_cnt_reg     <= '0;
         word_cnt_reg    <= '0;
         idle_cnt_reg    <= '0;
         frame_done_reg  <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         sclk_sync_reg   <= {sclk_sync_reg[1:0], bus.serialClk};
         sdat_sync_reg   <= {sdat_sync_reg[0], bus.serialData};
         state_reg       <= state_next;
         shift_reg       <= shift_next;
         bit_cnt_reg     <= bit_cnt_next;
         word_cnt_reg    <= word_cnt_next;
         idle_cnt_reg    <= idle_cnt_next;
         frame_done_reg  <= frame_done_next;
         frame_error_reg <= frame_error_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      bit_cnt_next    = bit_cnt_reg;
      word_cnt_next   = word_cnt_reg;
      idle_cnt_next   = idle_cnt_reg;
      frame_done_next = 1'b0;
      push            = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            bit_cnt_next  = '0;
            word_cnt_next = '0;
            idle_cnt_next = '0;
            if (space_ok) begin
               state_next = ST_READY;
            end
         end
         ST_READY: begin
            if (serial_edge) begin
               shift_next    = shift_in;
               bit_cnt_next  = BIT_W'(1);
               idle_cnt_next = '0;
               state_next    = ST_RECV;
            end
         end
         ST_RECV: begin
            if (serial_edge) begin
               shift_next    = shift_in;
               idle_cnt_next = '0;
               if (bit_cnt_reg == BIT_W'(DATA_W - 1)) begin
                  push         = 1'b1;
                  bit_cnt_next = '0;
                  if (word_cnt_reg == WORD_W'(FRAME_BYTES - 1)) begin
                     word_cnt_next   = '0;
                     frame_done_next = 1'b1;
                     state_next      = ST_IDLE;
                  end else begin
                     word_cnt_next = word_cnt_reg + WORD_W'(1);
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
               end
            end else if (idle_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
               state_next = ST_ERR;
            end else begin
               idle_cnt_next = idle_cnt_reg + TMO_W'(1);
            end
         end
         ST_ERR: begin
            // partial word is simply left in the shift register and forgotten
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      // a fresh error outranks a simultaneous clear
      if ((state_reg == ST_ERR) || overflow) begin
         frame_error_next = 1'b1;
      end else if (bus.clrError) begin
         frame_error_next = 1'b0;
      end else begin
         frame_error_next = frame_error_reg;
      end
   end

   assign bus.readyForTransfer = (state_reg == ST_READY);
   assign bus.transferActive   = (state_reg == ST_RECV);
   assign bus.frameDone        = frame_done_reg;
   assign bus.frameError       = frame_error_reg;
   assign bus.count            = fifo_count;

   scanner_rx_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (push),
      .wr_data  (shift_in),
      .rd_en    (bus.rdEn),
      .rd_data  (bus.rdData),
      .empty    (bus.empty),
      .full     (bus.full),
      .count    (fifo_count),
      .overflow (overflow)
   );
endmodule

// File: tb/tb_scanner_receiver.sv
// Self-checking bench for scanner_receiver: drives the scanner serial link and
// scoreboards every popped word against the bytes that were sent.
module tb_scanner_receiver;
   import scanner_link_pkg::*;

   localparam int DW    = 8;
   localparam int FB    = 8;
   localparam int DEPTH = 16;
   localparam int TMO   = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scanner_receiver_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

   scanner_receiver #(
      .DATA_W      (DW),
      .FRAME_BYTES (FB),
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT     (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          errors    = 0;
   int          checks    = 0;
   int          done_cnt  = 0;
   int          max_count = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  exp_b;
   logic        pend = 1'b0;

   // pop monitor: a pop issued before a clk edge is checked just after the next falling edge
   always @(negedge clk) begin
      #1;
      if (bus.frameDone === 1'b1) done_cnt++;
      if (int'(bus.count) > max_count) max_count = int'(bus.count);
      if (pend) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_data: got %h, expected no word", bus.rdData);
         end else begin
            exp_b = exp_q.pop_front();
            if (bus.rdData !== exp_b) begin
               errors++;
               $display("FAIL pop_data: got %h, expected %h", bus.rdData, exp_b);
            end else begin
               $display("pop  data=%h", bus.rdData);
            end
         end
      end
      pend = (bus.rdEn === 1'b1) && (bus.empty === 1'b0) && (rst === 1'b0);
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b, input logic pop);
      @(negedge clk);
      bus.serialClk  = 1'b0;
      bus.serialData = b;
      repeat (3) @(negedge clk);
      bus.serialClk = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (pop) bus.rdEn = 1'b1;   // lands on the same clk edge as the word push
      @(negedge clk);
      if (pop) bus.rdEn = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic pop_last);
      exp_q.push_back(b);
      $display("send data=%h", b);
      for (int i = 7; i >= 0; i--) send_bit(b[i], pop_last && (i == 0));
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.readyForTransfer !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.readyForTransfer !== 1'b1) begin
         errors++;
         $display("FAIL %s: readyForTransfer=%b after %0d clk, expected 1", tag, bus.readyForTransfer, n);
      end
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.rdEn = 1'b1;
         @(negedge clk);
         bus.rdEn = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic send_random_frame(input string tag);
      wait_ready(tag);
      for (int i = 0; i < FB; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (bus.readyForTransfer !== 1'b0 || bus.transferActive !== 1'b0) begin
         errors++; $display("FAIL por_ctrl: rft=%b act=%b, expected 0 0", bus.readyForTransfer, bus.transferActive);
      end
      if (bus.frameDone !== 1'b0 || bus.frameError !== 1'b0) begin
         errors++; $display("FAIL por_flags: done=%b err=%b, expected 0 0", bus.frameDone, bus.frameError);
      end
      if (bus.rdData !== 8'h00 || bus.count !== 5'd0) begin
         errors++; $display("FAIL por_data: rdData=%h count=%0d, expected 00 0", bus.rdData, bus.count);
      end
      if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
         errors++; $display("FAIL por_fifo: empty=%b full=%b, expected 1 0", bus.empty, bus.full);
      end
      rst = 1'b0;
      wait_ready("por_ready");

      // mid-frame reset after a pop left rdData non-zero
      send_byte(8'h5A, 1'b0);
      send_byte(8'hC3, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      pop_n(1);
      checks++;
      if (bus.transferActive !== 1'b1) begin
         errors++; $display("FAIL mid_active: transferActive=%b, expected 1", bus.transferActive);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.serialClk = 1'b0;
      exp_q.delete();
      #1;
      checks += 4;
      if (bus.readyForTransfer !== 1'b0 || bus.transferActive !== 1'b0) begin
         errors++; $display("FAIL rst_ctrl: rft=%b act=%b, expected 0 0", bus.readyForTransfer, bus.transferActive);
      end
      if (bus.frameDone !== 1'b0 || bus.frameError !== 1'b0) begin
         errors++; $display("FAIL rst_flags: done=%b err=%b, expected 0 0", bus.frameDone, bus.frameError);
      end
      if (bus.rdData !== 8'h00 || bus.count !== 5'd0) begin
         errors++; $display("FAIL rst_data: rdData=%h count=%0d, expected 00 0", bus.rdData, bus.count);
      end
      if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
         errors++; $display("FAIL rst_fifo: empty=%b full=%b, expected 1 0", bus.empty, bus.full);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.readyForTransfer !== 1'b1) begin
         errors++; $display("FAIL rst_rearm: readyForTransfer=%b 2 clk after release, expected 1", bus.readyForTransfer);
      end
   endtask

   task automatic test_one_frame();
      logic [7:0] frame [FB] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'hFF};
      int d0 = done_cnt;
      wait_ready("frame_ready");
      for (int i = 0; i < FB; i++) begin
         send_byte(frame[i], 1'b0);
         if (i == 3) begin
            checks++;
            if (bus.transferActive !== 1'b1 || bus.readyForTransfer !== 1'b0) begin
               errors++; $display("FAIL frame_mid: act=%b rft=%b, expected 1 0", bus.transferActive, bus.readyForTransfer);
            end
         end
      end
      repeat (4) @(negedge clk);
      checks += 3;
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL frame_done: pulses=%0d, expected 1", done_cnt - d0);
      end
      if (bus.count !== 5'd8) begin
         errors++; $display("FAIL frame_count: count=%0d, expected 8", bus.count);
      end
      if (bus.frameError !== 1'b0) begin
         errors++; $display("FAIL frame_err: frameError=%b, expected 0", bus.frameError);
      end
      pop_n(FB);
      checks++;
      if (bus.empty !== 1'b1 || exp_q.size() != 0) begin
         errors++; $display("FAIL frame_drain: empty=%b left=%0d, expected 1 0", bus.empty, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      send_random_frame("bp_ready1");
      send_random_frame("bp_ready2");
      repeat (6) @(negedge clk);
      checks += 2;
      if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
         errors++; $display("FAIL bp_full: count=%0d full=%b, expected 16 1", bus.count, bus.full);
      end
      if (bus.readyForTransfer !== 1'b0) begin
         errors++; $display("FAIL bp_hold: readyForTransfer=%b, expected 0", bus.readyForTransfer);
      end
      pop_n(8);
      wait_ready("bp_rearm");
      checks++;
      if (bus.count !== 5'd8) begin
         errors++; $display("FAIL bp_count: count=%0d, expected 8", bus.count);
      end
      pop_n(8);
   endtask

   task automatic test_timeout();
      wait_ready("tmo_ready");
      send_byte(8'h96, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      repeat (TMO - 20) @(negedge clk);
      checks++;
      if (bus.frameError !== 1'b0) begin
         errors++; $display("FAIL tmo_early: frameError=%b before timeout, expected 0", bus.frameError);
      end
      repeat (30) @(negedge clk);
      checks += 2;
      if (bus.frameError !== 1'b1 || bus.transferActive !== 1'b0) begin
         errors++; $display("FAIL tmo_err: frameError=%b act=%b, expected 1 0", bus.frameError, bus.transferActive);
      end
      if (bus.count !== 5'd1) begin
         errors++; $display("FAIL tmo_count: count=%0d, expected 1", bus.count);
      end
      @(negedge clk);
      bus.clrError = 1'b1;
      @(negedge clk);
      bus.clrError = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.frameError !== 1'b0) begin
         errors++; $display("FAIL tmo_clr: frameError=%b after clrError, expected 0", bus.frameError);
      end
      pop_n(1);
   endtask

   task automatic test_idle_edges();
      send_random_frame("idle_ready1");
      send_random_frame("idle_ready2");
      for (int i = 0; i < 10; i++) begin
         repeat (3) @(negedge clk);
         bus.serialData = 1'($urandom_range(0, 1));
         bus.serialClk  = ~bus.serialClk;
      end
      repeat (6) @(negedge clk);
      checks += 2;
      if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
         errors++; $display("FAIL idle_count: count=%0d full=%b, expected 16 1", bus.count, bus.full);
      end
      if (bus.frameError !== 1'b0 || bus.transferActive !== 1'b0) begin
         errors++; $display("FAIL idle_err: frameError=%b act=%b, expected 0 0", bus.frameError, bus.transferActive);
      end
      pop_n(16);
   endtask

   task automatic test_back_to_back();
      send_random_frame("b2b_ready1");
      wait_ready("b2b_ready2");
      for (int i = 0; i < FB; i++) begin
         send_byte(8'($urandom_range(0, 255)), 1'b1);
         checks++;
         if (bus.count !== 5'd8) begin
            errors++; $display("FAIL b2b_count: byte %0d count=%0d, expected 8", i, bus.count);
         end
      end
      repeat (4) @(negedge clk);
      pop_n(8);

      // rdEn held for a whole frame: every word leaves right after it lands
      wait_ready("held_ready");
      max_count = 0;
      bus.rdEn  = 1'b1;
      for (int i = 0; i < FB; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      repeat (4) @(negedge clk);
      bus.rdEn = 1'b0;
      repeat (2) @(negedge clk);
      checks += 2;
      if (max_count > 1) begin
         errors++; $display("FAIL held_bound: max count=%0d, expected <= 1", max_count);
      end
      if (bus.empty !== 1'b1 || exp_q.size() != 0) begin
         errors++; $display("FAIL held_drain: empty=%b left=%0d, expected 1 0", bus.empty, exp_q.size());
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.serialClk  = 1'b0;
      bus.serialData = 1'b0;
      bus.clrError   = 1'b0;
      bus.rdEn       = 1'b0;
      test_reset();
      test_one_frame();
      test_backpressure();
      test_timeout();
      test_idle_edges();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
